uart_receiver: RTL and testbench

UART_RECEIVER -- requirements
Module: uart_receiver

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_sync.sv | 24 ++
 rtl/uart_receiver.sv | 179 +++++++++++++++++
 tb/tb_uart_receiver.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART receiver slice.
// UART_RX_PARITY_EN adds the PARITY state.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_HIGH
  } state_t;

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for the async rxd line.
// Resets to 1 so reset release never looks like a start bit.
module uart_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= (sync_q << 1) | SYNC_STAGES'(d_i);
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// 8-bit UART receiver, bit-centre sampling, one-cycle strobes.
// Define UART_RX_PARITY_EN for an even-parity bit and parity_error.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = 434,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] received_data,
  output logic                 data_valid,
  output logic                 framing_error,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_error,
`endif
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLK_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_PER_BIT / 2 - 1);
  localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

  if (CLK_PER_BIT < 4) begin : g_bad_cpb
    $error("uart_receiver: CLK_PER_BIT must be at least 4");
  end

  logic rxd_s;

  uart_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d_i  (rxd),
    .q_o  (rxd_s)
  );

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 dv_q, dv_d;
  logic                 fe_q, fe_d;
`ifdef UART_RX_PARITY_EN
  logic                 pe_q, pe_d;
  logic                 pbad_q, pbad_d;
`endif

  logic tick;
  assign tick = (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pe_q    <= 1'b0;
      pbad_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      fe_q    <= fe_d;
`ifdef UART_RX_PARITY_EN
      pe_q    <= pe_d;
      pbad_q  <= pbad_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    fe_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    pe_d    = 1'b0;
    pbad_d  = pbad_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (!rxd_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rxd_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (tick) begin
          cnt_d   = '0;
          shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          cnt_d   = '0;
          pbad_d  = rxd_s != (^shift_q);
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      STOP: begin
        if (tick) begin
          cnt_d = '0;
          // Framing error wins over parity; data only loads on a clean frame.
          if (!rxd_s) begin
            fe_d    = 1'b1;
            state_d = WAIT_HIGH;
`ifdef UART_RX_PARITY_EN
          end else if (pbad_q) begin
            pe_d    = 1'b1;
            state_d = IDLE;
`endif
          end else begin
            data_d  = shift_q;
            dv_d    = 1'b1;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_HIGH: begin
        if (rxd_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign received_data = data_q;
  assign data_valid    = dv_q;
  assign framing_error = fe_q;
`ifdef UART_RX_PARITY_EN
  assign parity_error  = pe_q;
`endif
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed self-checking bench for uart_receiver at CLK_PER_BIT=16.
// Define UART_RX_PARITY_EN to also exercise the parity path.
module tb_uart_receiver;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 171;
`else
  localparam int LAT = 155;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rxd = 1'b1;
  logic [7:0] received_data;
  logic       data_valid;
  logic       framing_error;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_error;
  wire        pe_w = parity_error;
`else
  wire        pe_w = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  uart_receiver #(
    .CLK_PER_BIT(CPB),
    .SYNC_STAGES(2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rxd          (rxd),
    .received_data(received_data),
    .data_valid   (data_valid),
    .framing_error(framing_error),
`ifdef UART_RX_PARITY_EN
    .parity_error (parity_error),
`endif
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int         cyc = 0;
  int         dv_cnt = 0;
  int         fe_cnt = 0;
  int         pe_cnt = 0;
  int         viol = 0;
  int         dv_cyc = 0;
  logic [7:0] dv_q[$];
  logic       prev_any = 1'b0;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (data_valid) begin
      dv_cnt++;
      dv_cyc = cyc;
      dv_q.push_back(received_data);
    end
    if (framing_error) fe_cnt++;
    if (pe_w) pe_cnt++;
    if (int'(data_valid) + int'(framing_error) + int'(pe_w) > 1) viol++;
    if (prev_any && (data_valid || framing_error || pe_w)) viol++;
    prev_any = data_valid || framing_error || pe_w;
  end

  task automatic send_bit(input logic b);
    rxd = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b,
                            input logic par_b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par_b);
`else
    if (par_b === 1'bx) rxd = 1'b1;
`endif
    send_bit(stop_b);
    rxd = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] d);
    send_frame(d, 1'b1, ^d);
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    rxd = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (received_data !== 8'h00) begin
      errors++;
      $display("FAIL rst_data: got %0h expected 00", received_data);
    end
    checks++;
    if (data_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_dv: got %b expected 0", data_valid);
    end
    checks++;
    if (framing_error !== 1'b0) begin
      errors++;
      $display("FAIL rst_fe: got %b expected 0", framing_error);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_busy: got %b expected 0", busy);
    end
    reset = 1'b0;
    idle(5);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_release_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_single;
    int n0;
    int t0;
    n0 = dv_cnt;
    t0 = cyc;
    send_byte(8'hA5);
    idle(20);
    checks++;
    if (dv_cnt - n0 !== 1) begin
      errors++;
      $display("FAIL a5_count: got %0d expected 1", dv_cnt - n0);
    end
    checks++;
    if (dv_q.size() == 0 || dv_q[$] !== 8'hA5) begin
      errors++;
      $display("FAIL a5_strobe_data: got %0h expected a5",
               dv_q.size() ? dv_q[$] : 8'hxx);
    end
    checks++;
    if (received_data !== 8'hA5) begin
      errors++;
      $display("FAIL a5_hold: got %0h expected a5", received_data);
    end
    checks++;
    if (dv_cyc - t0 !== LAT) begin
      errors++;
      $display("FAIL a5_latency: got %0d expected %0d", dv_cyc - t0, LAT);
    end
  endtask

  task automatic test_back_to_back;
    int n0;
    n0 = dv_cnt;
    repeat (4) send_byte(8'hFF);
    idle(40);
    checks++;
    if (dv_cnt - n0 !== 4) begin
      errors++;
      $display("FAIL b2b_count: got %0d expected 4", dv_cnt - n0);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dv_q.size() < 4 || dv_q[dv_q.size() - 4 + i] !== 8'hFF) begin
        errors++;
        $display("FAIL b2b_data%0d: got %0h expected ff", i,
                 dv_q.size() >= 4 ? dv_q[dv_q.size() - 4 + i] : 8'hxx);
      end
    end
  endtask

  task automatic test_glitch;
    int n0;
    int f0;
    int k;
    n0 = dv_cnt;
    f0 = fe_cnt;
    rxd = 1'b0;
    repeat (5) @(negedge clk);
    rxd = 1'b1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL glitch_busy_hi: got %b expected 1", busy);
    end
    k = 0;
    while (busy && k < 8) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL glitch_busy_lo: got %b expected 0 after %0d clk",
               busy, k);
    end
    idle(30);
    checks++;
    if (dv_cnt != n0 || fe_cnt != f0) begin
      errors++;
      $display("FAIL glitch_strobe: got dv %0d fe %0d expected 0 0",
               dv_cnt - n0, fe_cnt - f0);
    end
  endtask

  task automatic test_framing;
    int n0;
    int f0;
    n0 = dv_cnt;
    f0 = fe_cnt;
    send_frame(8'h3C, 1'b0, ^8'h3C);
    idle(30);
    checks++;
    if (fe_cnt - f0 !== 1) begin
      errors++;
      $display("FAIL fe_count: got %0d expected 1", fe_cnt - f0);
    end
    checks++;
    if (dv_cnt != n0) begin
      errors++;
      $display("FAIL fe_no_dv: got %0d expected 0", dv_cnt - n0);
    end
    checks++;
    if (received_data !== 8'hFF) begin
      errors++;
      $display("FAIL fe_hold: got %0h expected ff", received_data);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL fe_recover_busy: got %b expected 0", busy);
    end
    send_byte(8'h12);
    idle(20);
    checks++;
    if (dv_cnt - n0 !== 1) begin
      errors++;
      $display("FAIL fe_next_count: got %0d expected 1", dv_cnt - n0);
    end
    checks++;
    if (received_data !== 8'h12) begin
      errors++;
      $display("FAIL fe_next_data: got %0h expected 12", received_data);
    end
  endtask

  task automatic test_reset_midframe;
    int n0;
    int f0;
    logic [7:0] d;
    d = 8'h81;
    n0 = dv_cnt;
    f0 = fe_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    rxd = d[4];
    repeat (CPB / 2) @(negedge clk);
    reset = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    send_bit(d[5]);
    send_bit(d[6]);
    rxd = d[7];
    repeat (CPB / 2) @(negedge clk);
    checks++;
    if (received_data !== 8'h00) begin
      errors++;
      $display("FAIL mid_rst_data: got %0h expected 00", received_data);
    end
    checks++;
    if (data_valid !== 1'b0 || framing_error !== 1'b0 || pe_w !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_strobes: got %b%b%b expected 000",
               data_valid, framing_error, pe_w);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_busy: got %b expected 0", busy);
    end
    reset = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    send_bit(1'b1);
    idle(20);
    checks++;
    if (dv_cnt != n0 || fe_cnt != f0) begin
      errors++;
      $display("FAIL mid_rst_no_strobe: got dv %0d fe %0d expected 0 0",
               dv_cnt - n0, fe_cnt - f0);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_idle: got %b expected 0", busy);
    end
    send_byte(8'h42);
    idle(20);
    checks++;
    if (dv_cnt - n0 !== 1) begin
      errors++;
      $display("FAIL mid_rst_next_count: got %0d expected 1", dv_cnt - n0);
    end
    checks++;
    if (received_data !== 8'h42) begin
      errors++;
      $display("FAIL mid_rst_next_data: got %0h expected 42", received_data);
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int n0;
    int p0;
    n0 = dv_cnt;
    p0 = pe_cnt;
    send_frame(8'h07, 1'b1, 1'b0);
    idle(20);
    checks++;
    if (pe_cnt - p0 !== 1) begin
      errors++;
      $display("FAIL par_count: got %0d expected 1", pe_cnt - p0);
    end
    checks++;
    if (dv_cnt != n0) begin
      errors++;
      $display("FAIL par_no_dv: got %0d expected 0", dv_cnt - n0);
    end
    checks++;
    if (received_data !== 8'h42) begin
      errors++;
      $display("FAIL par_hold: got %0h expected 42", received_data);
    end
  endtask
`endif

  task automatic test_exclusive;
    checks++;
    if (viol !== 0) begin
      errors++;
      $display("FAIL strobe_exclusive: got %0d violations expected 0", viol);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_single;
    test_back_to_back;
    test_glitch;
    test_framing;
    test_reset_midframe;
`ifdef UART_RX_PARITY_EN
    test_parity;
`endif
    test_exclusive;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
